// File: rtl/snd_pkg.sv
// Shared constants for the sound SDRAM arbiter: default parameters,
// FSM state encoding and the word returned on a timed-out read.
package snd_pkg;

  localparam int AW_DEF         = 25;
  localparam int STARVE_MAX_DEF = 4;
  localparam int TIMEOUT_DEF    = 1023;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ISSUE = 2'd1;
  localparam state_t ST_WAIT  = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  localparam logic [63:0] ERR_WORD = 64'hFFFF_FFFF_FFFF_FFFF;

endpackage

// File: rtl/snd_sdr_arb_if.sv
// Bundle of the two requester ports and the SDRAM controller side.
// slave = the arbiter, master = whoever drives requests and SDRAM responses.
interface snd_sdr_arb_if
  import snd_pkg::*;
#(
  parameter int AW = AW_DEF
);

  logic          p0_req;
  logic [AW-1:0] p0_addr;
  logic          p0_rdy;
  logic          p1_req;
  logic [AW-1:0] p1_addr;
  logic          p1_rdy;
  logic [63:0]   rd_data;
  logic          rd_err;
  logic [AW-1:0] sdr_addr;
  logic          sdr_req;
  logic [63:0]   sdr_data;
  logic          sdr_rdy;

  modport slave (
    input  p0_req, p0_addr, p1_req, p1_addr, sdr_data, sdr_rdy,
    output p0_rdy, p1_rdy, rd_data, rd_err, sdr_addr, sdr_req
  );

  modport master (
    output p0_req, p0_addr, p1_req, p1_addr, sdr_data, sdr_rdy,
    input  p0_rdy, p1_rdy, rd_data, rd_err, sdr_addr, sdr_req
  );

endinterface

// File: rtl/snd_arb_pick.sv
// Two-port arbiter decision: port 0 has fixed priority, but port 1 is
// forced through once port 0 has been granted STARVE_MAX times in a row
// while port 1 was waiting.
module snd_arb_pick
  import snd_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF
)(
  input  logic clk_sys,
  input  logic reset,
  input  logic p0_req,
  input  logic p1_req,
  input  logic grant,
  output logic valid,
  output logic pick_p1
);

  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] STARVE_V = CW'(STARVE_MAX);

  logic [CW-1:0] starve_cnt;

  assign valid   = p0_req | p1_req;
  assign pick_p1 = p1_req & (~p0_req | (starve_cnt == STARVE_V));

  // Count port-0 grants that bypassed a waiting port 1; reset when port 1 is served or stops asking.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (!p1_req || (grant && pick_p1)) begin
      starve_cnt <= '0;
    end else if (grant && (starve_cnt != STARVE_V)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/snd_sdr_arb.sv
// Shares one SDRAM read channel between the GA20 sample cache (port 0)
// and the sound ROM prefetcher (port 1). One access is outstanding at a
// time; a stuck SDRAM response is cut off after TIMEOUT+1 wait cycles and
// answered with an all-ones word and an error pulse.
module snd_sdr_arb
  import snd_pkg::*;
#(
  parameter int AW         = AW_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF
)(
  input  logic clk_sys,
  input  logic reset,
  input  logic paused,
  snd_sdr_arb_if.slave bus
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TIMEOUT_V = TW'(TIMEOUT);

  state_t        state;
  logic          owner;
  logic [AW-1:0] addr_q;
  logic [TW-1:0] tmo_cnt;

  logic          sdr_req_q;
  logic [AW-1:0] sdr_addr_q;
  logic [63:0]   rd_data_q;
  logic          p0_rdy_q;
  logic          p1_rdy_q;
  logic          rd_err_q;

  logic          pick_valid;
  logic          pick_p1;
  logic          grant;

  assign grant = (state == ST_IDLE) && !paused && pick_valid;

  snd_arb_pick #(
    .STARVE_MAX(STARVE_MAX)
  ) u_pick (
    .clk_sys(clk_sys),
    .reset(reset),
    .p0_req(bus.p0_req),
    .p1_req(bus.p1_req),
    .grant(grant),
    .valid(pick_valid),
    .pick_p1(pick_p1)
  );

  assign bus.sdr_req  = sdr_req_q;
  assign bus.sdr_addr = sdr_addr_q;
  assign bus.rd_data  = rd_data_q;
  assign bus.p0_rdy   = p0_rdy_q;
  assign bus.p1_rdy   = p1_rdy_q;
  assign bus.rd_err   = rd_err_q;

  // Access sequencer: grant in IDLE, drive SDRAM in ISSUE, wait for data or timeout, then pulse the owner's rdy.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state      <= ST_IDLE;
      owner      <= 1'b0;
      addr_q     <= '0;
      tmo_cnt    <= '0;
      sdr_req_q  <= 1'b0;
      sdr_addr_q <= '0;
      rd_data_q  <= '0;
      p0_rdy_q   <= 1'b0;
      p1_rdy_q   <= 1'b0;
      rd_err_q   <= 1'b0;
    end else begin
      p0_rdy_q <= 1'b0;
      p1_rdy_q <= 1'b0;
      rd_err_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant) begin
            owner  <= pick_p1;
            addr_q <= pick_p1 ? bus.p1_addr : bus.p0_addr;
            state  <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          sdr_addr_q <= addr_q;
          sdr_req_q  <= 1'b1;
          tmo_cnt    <= '0;
          state      <= ST_WAIT;
        end
        ST_WAIT: begin
          if (bus.sdr_rdy) begin
            rd_data_q <= bus.sdr_data;
            sdr_req_q <= 1'b0;
            p0_rdy_q  <= ~owner;
            p1_rdy_q  <= owner;
            state     <= ST_DONE;
          end else if (tmo_cnt == TIMEOUT_V) begin
            rd_data_q <= ERR_WORD;
            sdr_req_q <= 1'b0;
            rd_err_q  <= 1'b1;
            p0_rdy_q  <= ~owner;
            p1_rdy_q  <= owner;
            state     <= ST_DONE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_snd_sdr_arb.sv
// Directed bench for snd_sdr_arb: single access, starvation rotation,
// pause, timeout, late-response boundary and reset mid-access.
module tb_snd_sdr_arb;

  logic clk_sys = 1'b0;
  logic reset;
  logic paused;

  int checks   = 0;
  int failures = 0;

  logic [1:0] rdys;
  logic       err;

  snd_sdr_arb_if #(.AW(25)) bus ();

  snd_sdr_arb #(
    .AW(25),
    .STARVE_MAX(4),
    .TIMEOUT(1023)
  ) dut (
    .clk_sys(clk_sys),
    .reset(reset),
    .paused(paused),
    .bus(bus)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic check64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for the arbiter to raise sdr_req.
  task automatic wait_req(input string tag);
    int n;
    n = 0;
    while (!bus.sdr_req && n < 50) begin
      tick();
      n++;
    end
    check1(tag, bus.sdr_req, 1'b1);
  endtask

  // Answer the current SDRAM request after 'delay' extra wait cycles.
  task automatic serve(input string tag, input int delay, input logic [63:0] data,
                       output logic [1:0] rdy_out, output logic err_out);
    wait_req(tag);
    repeat (delay) tick();
    bus.sdr_rdy  = 1'b1;
    bus.sdr_data = data;
    tick();
    bus.sdr_rdy  = 1'b0;
    rdy_out = {bus.p1_rdy, bus.p0_rdy};
    err_out = bus.rd_err;
  endtask

  initial begin
    int n;
    logic [1:0] exp_rdy;

    reset        = 1'b1;
    paused       = 1'b0;
    bus.p0_req   = 1'b0;
    bus.p0_addr  = '0;
    bus.p1_req   = 1'b0;
    bus.p1_addr  = '0;
    bus.sdr_rdy  = 1'b0;
    bus.sdr_data = '0;
    repeat (3) tick();

    check1("rst_sdr_req", bus.sdr_req, 1'b0);
    check64("rst_sdr_addr", 64'(bus.sdr_addr), 64'h0);
    check64("rst_rd_data", bus.rd_data, 64'h0);
    check1("rst_p0_rdy", bus.p0_rdy, 1'b0);
    check1("rst_p1_rdy", bus.p1_rdy, 1'b0);
    check1("rst_rd_err", bus.rd_err, 1'b0);

    reset = 1'b0;
    tick();

    // stray sdr_rdy while idle must be ignored
    bus.sdr_rdy  = 1'b1;
    bus.sdr_data = 64'hDEAD_BEEF_DEAD_BEEF;
    tick();
    bus.sdr_rdy = 1'b0;
    check1("stray_p0_rdy", bus.p0_rdy, 1'b0);
    check1("stray_p1_rdy", bus.p1_rdy, 1'b0);
    check64("stray_rd_data", bus.rd_data, 64'h0);

    // single port-0 read
    bus.p0_addr = 25'h01234;
    bus.p0_req  = 1'b1;
    tick();
    check1("issue_sdr_req_low", bus.sdr_req, 1'b0);
    tick();
    check1("wait_sdr_req", bus.sdr_req, 1'b1);
    check64("wait_sdr_addr", 64'(bus.sdr_addr), 64'h1234);
    repeat (4) tick();
    bus.sdr_rdy  = 1'b1;
    bus.sdr_data = 64'hA5A5_A5A5_A5A5_A5A5;
    tick();
    bus.sdr_rdy = 1'b0;
    bus.p0_req  = 1'b0;
    check1("rd0_p0_rdy", bus.p0_rdy, 1'b1);
    check1("rd0_p1_rdy", bus.p1_rdy, 1'b0);
    check1("rd0_rd_err", bus.rd_err, 1'b0);
    check64("rd0_rd_data", bus.rd_data, 64'hA5A5_A5A5_A5A5_A5A5);
    check1("rd0_sdr_req_low", bus.sdr_req, 1'b0);
    tick();
    check1("rd0_p0_rdy_pulse", bus.p0_rdy, 1'b0);
    check64("rd0_rd_data_hold", bus.rd_data, 64'hA5A5_A5A5_A5A5_A5A5);
    check64("rd0_sdr_addr_hold", 64'(bus.sdr_addr), 64'h1234);

    // both ports requesting: p0 x4 then p1, repeating
    bus.p0_addr = 25'h00100;
    bus.p1_addr = 25'h00200;
    bus.p0_req  = 1'b1;
    bus.p1_req  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      serve($sformatf("rot%0d_req", i), 2, 64'h1000 + 64'(i), rdys, err);
      exp_rdy = ((i % 5) == 4) ? 2'b10 : 2'b01;
      check64($sformatf("rot%0d_owner", i), 64'(rdys), 64'(exp_rdy));
      check64($sformatf("rot%0d_data", i), bus.rd_data, 64'h1000 + 64'(i));
    end
    bus.p0_req = 1'b0;
    bus.p1_req = 1'b0;
    repeat (3) tick();

    // paused holds off grants, release grants within 2 cycles
    paused      = 1'b1;
    bus.p1_addr = 25'h00300;
    bus.p1_req  = 1'b1;
    repeat (5) tick();
    check1("paused_no_req", bus.sdr_req, 1'b0);
    paused = 1'b0;
    tick();
    tick();
    check1("unpause_sdr_req", bus.sdr_req, 1'b1);
    check64("unpause_sdr_addr", 64'(bus.sdr_addr), 64'h300);
    serve("unpause_serve", 0, 64'h3333, rdys, err);
    check64("unpause_owner", 64'(rdys), 64'h2);
    bus.p1_req = 1'b0;
    tick();

    // timeout; p1 drops its request mid-access and still gets rdy
    bus.p1_addr = 25'h0ABCD;
    bus.p1_req  = 1'b1;
    wait_req("tmo_req");
    bus.p1_req = 1'b0;
    n = 1;
    while (bus.sdr_req && n < 2000) begin
      tick();
      if (bus.sdr_req) n++;
    end
    check64("tmo_wait_cycles", 64'(n), 64'd1024);
    check1("tmo_p1_rdy", bus.p1_rdy, 1'b1);
    check1("tmo_p0_rdy", bus.p0_rdy, 1'b0);
    check1("tmo_rd_err", bus.rd_err, 1'b1);
    check64("tmo_rd_data", bus.rd_data, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    check1("tmo_rd_err_pulse", bus.rd_err, 1'b0);
    check1("tmo_p1_rdy_pulse", bus.p1_rdy, 1'b0);

    // response arriving exactly on the timeout cycle counts as success
    bus.p0_addr = 25'h0F0F0;
    bus.p0_req  = 1'b1;
    wait_req("late_req");
    bus.p0_req = 1'b0;
    repeat (1023) tick();
    check1("late_still_waiting", bus.sdr_req, 1'b1);
    bus.sdr_rdy  = 1'b1;
    bus.sdr_data = 64'h1122_3344_5566_7788;
    tick();
    bus.sdr_rdy = 1'b0;
    check1("late_p0_rdy", bus.p0_rdy, 1'b1);
    check1("late_rd_err", bus.rd_err, 1'b0);
    check64("late_rd_data", bus.rd_data, 64'h1122_3344_5566_7788);
    tick();

    // reset in WAIT, then a late sdr_rdy
    bus.p0_addr = 25'h00777;
    bus.p0_req  = 1'b1;
    wait_req("rstw_req");
    repeat (2) tick();
    reset      = 1'b1;
    bus.p0_req = 1'b0;
    tick();
    reset        = 1'b0;
    bus.sdr_rdy  = 1'b1;
    bus.sdr_data = 64'h9999_9999_9999_9999;
    tick();
    bus.sdr_rdy = 1'b0;
    check1("rstw_p0_rdy", bus.p0_rdy, 1'b0);
    check1("rstw_p1_rdy", bus.p1_rdy, 1'b0);
    check1("rstw_rd_err", bus.rd_err, 1'b0);
    check1("rstw_sdr_req", bus.sdr_req, 1'b0);
    check64("rstw_sdr_addr", 64'(bus.sdr_addr), 64'h0);
    check64("rstw_rd_data", bus.rd_data, 64'h0);
    tick();
    check1("rstw_p0_rdy_after", bus.p0_rdy, 1'b0);

    // arbiter back in IDLE: fresh request issues two cycles later
    bus.p1_addr = 25'h00055;
    bus.p1_req  = 1'b1;
    tick();
    tick();
    check1("post_rst_sdr_req", bus.sdr_req, 1'b1);
    check64("post_rst_sdr_addr", 64'(bus.sdr_addr), 64'h55);
    serve("post_rst_serve", 1, 64'h5555, rdys, err);
    check64("post_rst_owner", 64'(rdys), 64'h2);
    check64("post_rst_data", bus.rd_data, 64'h5555);
    bus.p1_req = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
